gbuf_rd_streamer: RTL and testbench

- Read-side sequencer directly downstream of the dual-port global buffer.
- On a start pulse it reads `len` consecutive words from `base`, two words per cycle (port 1 = even offset, port 2 = odd offset), and accounts for the buffer's 1-cycle registered read latency.
- It packs each word pair into a valid/ready stream toward the MMU compute array, and absorbs backpressure with a small output FIFO.

---
 rtl/gbuf_pkg.sv | 23 ++
 rtl/gbuf_rd_fifo.sv | 52 +++++
 rtl/gbuf_rd_streamer.sv | 118 +++++++++++
 tb/tb_gbuf_rd_streamer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbuf_pkg.sv
// Shared types for the global-buffer read streamer.
// Holds the FSM encoding, keep codes and the stream beat bundle.
package gbuf_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_LO   = 2'b01;

  typedef struct packed {
    logic [2*DATA_BITS-1:0] data;
    logic [1:0]             keep;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/gbuf_rd_fifo.sv
// Small synchronous FIFO of stream beats between the buffer read port
// and the valid/ready output; entries live in flops.
import gbuf_pkg::*;

module gbuf_rd_fifo #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push,
  input  beat_t                            push_beat,
  input  logic                             pop,
  output beat_t                            out_beat,
  output logic                             out_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  beat_t         mem [FIFO_DEPTH];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign out_valid = (count != '0);
  assign out_beat  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/gbuf_rd_streamer.sv
// Streams len words from the dual-port global buffer as word pairs,
// tracking the buffer's one-cycle registered read latency.
import gbuf_pkg::*;

module gbuf_rd_streamer #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDR_BITS-1:0]   base_addr_i,
  input  logic [ADDR_BITS:0]     len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   rd_own_o,
  output logic [ADDR_BITS-1:0]   index_1_o,
  output logic [ADDR_BITS-1:0]   index_2_o,
  input  logic [DATA_BITS-1:0]   data_out_1_i,
  input  logic [DATA_BITS-1:0]   data_out_2_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [2*DATA_BITS-1:0] m_data_o,
  output logic [1:0]             m_keep_o,
  output logic                   m_last_o
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  state_t               state;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS:0]   rem;
  logic                 inflight;
  logic [1:0]           if_keep;
  logic                 if_last;

  logic                 pop;
  logic                 issue;
  logic [CW-1:0]        cnt;
  logic [CW:0]          occ;
  beat_t                in_beat;
  beat_t                out_beat;

  assign pop = m_valid_o & m_ready_i;

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign occ = {1'b0, cnt} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = (state == RUN) && (occ < (CW+1)'(FIFO_DEPTH));

  assign in_beat.data = {data_out_2_i, data_out_1_i};
  assign in_beat.keep = if_keep;
  assign in_beat.last = if_last;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      rem      <= '0;
      inflight <= 1'b0;
      if_keep  <= '0;
      if_last  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        if_keep <= (rem > (ADDR_BITS+1)'(1)) ? KEEP_FULL : KEEP_LO;
        if_last <= (rem <= (ADDR_BITS+1)'(2));
        ptr     <= ptr + ADDR_BITS'(2);
        rem     <= (rem > (ADDR_BITS+1)'(1)) ? rem - (ADDR_BITS+1)'(2) : '0;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            // Zero length passes through an empty DRAIN to DONE.
            if (len_i == '0) begin
              state <= DRAIN;
            end else begin
              state <= RUN;
              ptr   <= base_addr_i;
              rem   <= len_i;
            end
          end
        end
        RUN: begin
          if (issue && (rem <= (ADDR_BITS+1)'(2))) state <= DRAIN;
        end
        DRAIN: begin
          if ((pop && m_last_o) || (cnt == '0 && !inflight)) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  gbuf_rd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (inflight),
    .push_beat (in_beat),
    .pop       (pop),
    .out_beat  (out_beat),
    .out_valid (m_valid_o),
    .count     (cnt)
  );

  assign m_data_o  = out_beat.data;
  assign m_keep_o  = out_beat.keep;
  assign m_last_o  = out_beat.last;

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign rd_own_o  = busy_o;
  assign index_1_o = (state == RUN) ? ptr : '0;
  assign index_2_o = (state == RUN) ? ptr + ADDR_BITS'(1) : '0;

endmodule

// File: tb/tb_gbuf_rd_streamer.sv
// Directed bench for gbuf_rd_streamer with a buffer model, a
// beat-list reference model and a per-cycle output monitor.
module tb_gbuf_rd_streamer;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic        l;
  } exp_t;

  logic        clk_i = 0;
  logic        rst_i = 0;
  logic        start_i = 0;
  logic [7:0]  base_addr_i = 0;
  logic [8:0]  len_i = 0;
  logic        busy_o, done_o, rd_own_o;
  logic [7:0]  index_1_o, index_2_o;
  logic [7:0]  data_out_1_i = 0;
  logic [7:0]  data_out_2_i = 0;
  logic        m_valid_o;
  logic        m_ready_i = 1;
  logic [15:0] m_data_o;
  logic [1:0]  m_keep_o;
  logic        m_last_o;

  gbuf_rd_streamer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .rd_own_o(rd_own_o),
    .index_1_o(index_1_o), .index_2_o(index_2_o),
    .data_out_1_i(data_out_1_i), .data_out_2_i(data_out_2_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_last_o(m_last_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] mem [256];
  int cyc = 0;
  int vec = 0;
  int errs = 0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    data_out_1_i <= mem[index_1_o];
    data_out_2_i <= mem[index_2_o];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  exp_t        exp_q[$];
  logic [15:0] got[$];
  logic [18:0] got_word[$];
  int   s_cyc = 0;
  int   last_hs = 0;
  int   cur_len = 0;
  bit   first_pending = 0;
  bit   done_flag = 0;
  bit   prev_done = 0;
  bit   prev_stall = 0;
  bit   idx_chk = 0;
  bit   mon_en = 0;
  logic [18:0] prev_word;
  int   pat[6] = '{1, 0, 0, 1, 0, 1};

  // Reference: beat list computed straight from base/len and buffer contents.
  task automatic load_model(input logic [7:0] base, input int len);
    int nb;
    logic [7:0] a;
    exp_t e;
    nb = (len + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      a = base + 8'(2 * k);
      e.d = {mem[8'(a + 8'd1)], mem[a]};
      e.k = (2 * k + 1 < len) ? 2'b11 : 2'b01;
      e.l = (k == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_stall = 0;
      prev_done = 0;
    end else if (mon_en) begin
      chk("rd_own", rd_own_o, busy_o);
      if (idx_chk && cyc == s_cyc + 1) begin
        chk("idx1_first", index_1_o, 8'hFF);
        chk("idx2_first", index_2_o, 8'h00);
      end
      if (idx_chk && cyc == s_cyc + 2) begin
        chk("idx1_second", index_1_o, 8'h01);
        chk("idx2_second", index_2_o, 8'h02);
      end
      if (done_o) begin
        chk("done_single", prev_done, 0);
        if (cur_len == 0) chk("done_lat_len0", cyc - s_cyc, 2);
        else chk("done_after_last", cyc - last_hs, 1);
        done_flag = 1;
      end
      prev_done = done_o;
      if (m_valid_o) begin
        if (first_pending) begin
          chk("first_valid_lat", cyc - s_cyc, 3);
          first_pending = 0;
        end
        if (prev_stall)
          chk("stable", {m_data_o, m_keep_o, m_last_o}, prev_word);
        if (exp_q.size() == 0) begin
          chk("extra_beat", m_data_o, 32'hDEAD_BEEF);
        end else begin
          chk("beat_data", m_data_o, exp_q[0].d);
          chk("beat_keep", m_keep_o, exp_q[0].k);
          chk("beat_last", m_last_o, exp_q[0].l);
        end
        if (m_ready_i) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got.push_back(m_data_o);
          got_word.push_back({m_data_o, m_keep_o, m_last_o});
          if (m_last_o) last_hs = cyc;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_word = {m_data_o, m_keep_o, m_last_o};
        end
      end else if (prev_stall) begin
        chk("valid_held", m_valid_o, 1);
        prev_stall = 0;
      end
    end
  end

  task automatic begin_xfer(input logic [7:0] base, input int len);
    got.delete();
    got_word.delete();
    load_model(base, len);
    cur_len = len;
    done_flag = 0;
    first_pending = (len != 0);
    mon_en = 1;
    @(posedge clk_i); #1;
    start_i = 1;
    base_addr_i = base;
    len_i = 9'(len);
    s_cyc = cyc;
    @(posedge clk_i); #1;
    start_i = 0;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic run(input logic [7:0] base, input int len,
                     input bit toggle, input bit restart);
    begin_xfer(base, len);
    m_ready_i = toggle ? 1'(pat[0]) : 1'b1;
    for (int i = 1; i < 300 && !done_flag; i++) begin
      @(posedge clk_i); #1;
      if (restart) begin
        start_i = (i == 1);
        base_addr_i = 8'h40;
        len_i = 9'd2;
      end
      m_ready_i = toggle ? 1'(pat[i % 6]) : 1'b1;
    end
    start_i = 0;
    m_ready_i = 1;
    chk("done_seen", done_flag, 1);
    chk("all_beats_out", exp_q.size(), 0);
    chk("idle_after", busy_o, 0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_idx", {index_1_o, index_2_o}, 0);
    @(posedge clk_i); #1;
    rst_i = 1;

    run(8'h10, 8, 0, 0);
    chk("t1_beats", got.size(), 4);
    if (got.size() == 4) begin
      chk("t1_b0", got[0], 16'h1110);
      chk("t1_b1", got[1], 16'h1312);
      chk("t1_b2", got[2], 16'h1514);
      chk("t1_b3", got[3], 16'h1716);
      chk("t1_b3_keep_last", got_word[3][2:0], 3'b111);
    end

    run(8'h20, 5, 0, 0);
    chk("t2_beats", got.size(), 3);
    if (got.size() == 3) begin
      chk("t2_b0", got[0], 16'h2120);
      chk("t2_b1", got[1], 16'h2322);
      chk("t2_b2_lo", got[2][7:0], 8'h24);
      chk("t2_b2_keep_last", got_word[2][2:0], 3'b011);
    end

    idx_chk = 1;
    run(8'hFF, 4, 0, 0);
    idx_chk = 0;
    chk("t3_beats", got.size(), 2);
    if (got.size() == 2) begin
      chk("t3_b0", got[0], 16'h00FF);
      chk("t3_b1", got[1], 16'h0201);
    end

    run(8'h30, 8, 1, 0);
    chk("t4_beats", got.size(), 4);
    if (got.size() == 4) chk("t4_b3", got[3], 16'h3736);

    run(8'h00, 0, 0, 0);
    chk("t5_no_beats", got.size(), 0);

    run(8'h10, 8, 0, 1);
    chk("t6_beats", got.size(), 4);
    if (got.size() == 4) chk("t6_b0", got[0], 16'h1110);

    // Reset during the stall of the second beat.
    begin_xfer(8'h10, 8);
    m_ready_i = 1;
    for (int i = 0; i < 20 && got.size() == 0; i++) begin
      @(posedge clk_i); #1;
    end
    m_ready_i = 0;
    chk("t7_beat1", got.size(), 1);
    @(posedge clk_i); #2;
    chk("t7_stalled", m_valid_o, 1);
    rst_i = 0;
    #1;
    chk("t7_busy", busy_o, 0);
    chk("t7_done", done_o, 0);
    chk("t7_valid", m_valid_o, 0);
    chk("t7_last", m_last_o, 0);
    chk("t7_keep", m_keep_o, 0);
    chk("t7_data", m_data_o, 0);
    chk("t7_idx", {index_1_o, index_2_o}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1;
    m_ready_i = 1;
    run(8'h00, 2, 0, 0);
    chk("t8_beats", got.size(), 1);
    if (got.size() == 1) chk("t8_b0", got_word[0], {16'h0100, 3'b111});

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
